// File: rtl/butterfly_seq_pkg.sv
// Shared types and width helpers for the butterfly stage sequencer.
package butterfly_seq_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } bfseq_state_t;

  // Index width for a table of 'depth' entries; never narrower than one bit.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stage_sample_buf.sv
// Frame buffer: N complex words, two async read ports, two write ports.
module stage_sample_buf
  import butterfly_seq_pkg::*;
#(
  parameter int n = 32,
  parameter int N = 8,
  localparam int AW = idx_w(N)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] rd_a_addr_i,
  input  logic [AW-1:0] rd_b_addr_i,
  output logic [n-1:0]  rd_a_r_o,
  output logic [n-1:0]  rd_a_c_o,
  output logic [n-1:0]  rd_b_r_o,
  output logic [n-1:0]  rd_b_c_o,
  input  logic          wa_en_i,
  input  logic [AW-1:0] wa_addr_i,
  input  logic [n-1:0]  wa_r_i,
  input  logic [n-1:0]  wa_c_i,
  input  logic          wb_en_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [n-1:0]  wb_r_i,
  input  logic [n-1:0]  wb_c_i
);

  logic [n-1:0] mem_r_q [N];
  logic [n-1:0] mem_c_q [N];

  assign rd_a_r_o = mem_r_q[rd_a_addr_i];
  assign rd_a_c_o = mem_c_q[rd_a_addr_i];
  assign rd_b_r_o = mem_r_q[rd_b_addr_i];
  assign rd_b_c_o = mem_c_q[rd_b_addr_i];

  // Contents survive reset; the two write ports never target the same entry.
  always_ff @(posedge clk_i) begin
    if (wa_en_i) begin
      mem_r_q[wa_addr_i] <= wa_r_i;
      mem_c_q[wa_addr_i] <= wa_c_i;
    end
    if (wb_en_i) begin
      mem_r_q[wb_addr_i] <= wb_r_i;
      mem_c_q[wb_addr_i] <= wb_c_i;
    end
  end

endmodule

// File: rtl/butterfly_stage_sequencer.sv
// One radix-2 DIT FFT stage: load a frame, run N/2 butterflies in place
// through an external shared butterfly, then stream the frame out in order.
module butterfly_stage_sequencer
  import butterfly_seq_pkg::*;
#(
  parameter int n = 32,
  parameter int d = 16,
  parameter int N = 8,
  parameter int s = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic [n-1:0]     recv_r,
  input  logic [n-1:0]     recv_c,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [n-1:0]     send_r,
  output logic [n-1:0]     send_c,
  input  logic [n*N/2-1:0] tw_r,
  input  logic [n*N/2-1:0] tw_c,
  output logic             bf_recv_val,
  input  logic             bf_recv_rdy,
  output logic [n-1:0]     bf_ar,
  output logic [n-1:0]     bf_ac,
  output logic [n-1:0]     bf_br,
  output logic [n-1:0]     bf_bc,
  output logic [n-1:0]     bf_wr,
  output logic [n-1:0]     bf_wc,
  input  logic             bf_send_val,
  output logic             bf_send_rdy,
  input  logic [n-1:0]     bf_cr,
  input  logic [n-1:0]     bf_cc,
  input  logic [n-1:0]     bf_dr,
  input  logic [n-1:0]     bf_dc
);

  localparam int AW    = idx_w(N);
  localparam int KW    = idx_w(N / 2);
  localparam int TW_SH = AW - 1 - s;

  bfseq_state_t  state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [KW-1:0] k_q, k_d;

  logic [AW-1:0] k_ext, pos, top, bot, rd_a_addr;
  logic [KW-1:0] tw_j;

  // Butterfly k pairs (top, top + 2^s) inside group k >> s.
  assign k_ext = AW'(k_q);
  assign pos   = k_ext & AW'((1 << s) - 1);
  assign top   = ((k_ext >> s) << (s + 1)) | pos;
  assign bot   = top | AW'(1 << s);
  assign tw_j  = KW'(pos << TW_SH);

  assign bf_wr = tw_r[n*tw_j +: n];
  assign bf_wc = tw_c[n*tw_j +: n];

  logic          wa_en, wb_en;
  logic [AW-1:0] wa_addr;
  logic [n-1:0]  wa_r, wa_c;
  logic [n-1:0]  rd_a_r, rd_a_c;

  assign rd_a_addr = (state_q == DRAIN) ? idx_q : top;
  assign send_r    = rd_a_r;
  assign send_c    = rd_a_c;
  assign bf_ar     = rd_a_r;
  assign bf_ac     = rd_a_c;

  stage_sample_buf #(.n(n), .N(N)) u_buf (
    .clk_i       (clk),
    .rd_a_addr_i (rd_a_addr),
    .rd_b_addr_i (bot),
    .rd_a_r_o    (rd_a_r),
    .rd_a_c_o    (rd_a_c),
    .rd_b_r_o    (bf_br),
    .rd_b_c_o    (bf_bc),
    .wa_en_i     (wa_en),
    .wa_addr_i   (wa_addr),
    .wa_r_i      (wa_r),
    .wa_c_i      (wa_c),
    .wb_en_i     (wb_en),
    .wb_addr_i   (bot),
    .wb_r_i      (bf_dr),
    .wb_c_i      (bf_dc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      idx_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    k_d         = k_q;
    recv_rdy    = 1'b0;
    send_val    = 1'b0;
    bf_recv_val = 1'b0;
    bf_send_rdy = 1'b0;
    wa_en       = 1'b0;
    wb_en       = 1'b0;
    wa_addr     = top;
    wa_r        = bf_cr;
    wa_c        = bf_cc;
    case (state_q)
      LOAD: begin
        recv_rdy = 1'b1;
        if (recv_val) begin
          wa_en   = 1'b1;
          wa_addr = idx_q;
          wa_r    = recv_r;
          wa_c    = recv_c;
          if (idx_q == AW'(N - 1)) begin
            idx_d   = '0;
            state_d = ISSUE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ISSUE: begin
        bf_recv_val = 1'b1;
        if (bf_recv_rdy) state_d = WAIT;
      end
      WAIT: begin
        // bf_send_val is only trusted here; the butterfly leaves it high after a result.
        if (bf_send_val) begin
          bf_send_rdy = 1'b1;
          wa_en       = 1'b1;
          wb_en       = 1'b1;
          if (k_q == KW'(N / 2 - 1)) begin
            k_d     = '0;
            state_d = DRAIN;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DRAIN: begin
        send_val = 1'b1;
        if (send_rdy) begin
          if (idx_q == AW'(N - 1)) begin
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

endmodule

// File: tb/tb_butterfly_stage_sequencer.sv
// Directed bench: three sequencers (s = 0, 1, 2) each paired with a
// two-cycle butterfly model that keeps send_val high after a result.
module tb_butterfly_stage_sequencer;

  localparam int NI  = 3;
  localparam int W   = 32;
  localparam int NS  = 8;
  localparam int TWW = W * NS / 2;
  localparam logic [31:0] ONE = 32'h0001_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           recv_val [NI], recv_rdy [NI], send_val [NI], send_rdy [NI];
  logic [W-1:0]   recv_r [NI], recv_c [NI], send_r [NI], send_c [NI];
  logic [TWW-1:0] tw_r [NI], tw_c [NI];
  logic           bf_recv_val [NI], bf_recv_rdy [NI], bf_send_val [NI], bf_send_rdy [NI];
  logic [W-1:0]   bf_ar [NI], bf_ac [NI], bf_br [NI], bf_bc [NI], bf_wr [NI], bf_wc [NI];
  logic [W-1:0]   bf_cr [NI], bf_cc [NI], bf_dr [NI], bf_dc [NI];

  int n_iss [NI];
  int n_cons [NI];
  int passed = 0;
  int total  = 0;

  function automatic logic [31:0] qm(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p[47:16];
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    butterfly_stage_sequencer #(.n(W), .d(16), .N(NS), .s(g)) dut (
      .clk(clk), .reset(reset),
      .recv_val(recv_val[g]), .recv_rdy(recv_rdy[g]),
      .recv_r(recv_r[g]), .recv_c(recv_c[g]),
      .send_val(send_val[g]), .send_rdy(send_rdy[g]),
      .send_r(send_r[g]), .send_c(send_c[g]),
      .tw_r(tw_r[g]), .tw_c(tw_c[g]),
      .bf_recv_val(bf_recv_val[g]), .bf_recv_rdy(bf_recv_rdy[g]),
      .bf_ar(bf_ar[g]), .bf_ac(bf_ac[g]), .bf_br(bf_br[g]), .bf_bc(bf_bc[g]),
      .bf_wr(bf_wr[g]), .bf_wc(bf_wc[g]),
      .bf_send_val(bf_send_val[g]), .bf_send_rdy(bf_send_rdy[g]),
      .bf_cr(bf_cr[g]), .bf_cc(bf_cc[g]), .bf_dr(bf_dr[g]), .bf_dc(bf_dc[g])
    );

    logic        busy_q, sv_q;
    int          cnt_q;
    logic [31:0] l_ar, l_ac, l_br, l_bc, l_wr, l_wc, pr, pc;
    logic [31:0] cr_q, cc_q, dr_q, dc_q;

    assign pr = qm(l_wr, l_br) - qm(l_wc, l_bc);
    assign pc = qm(l_wr, l_bc) + qm(l_wc, l_br);
    assign bf_recv_rdy[g] = !busy_q;
    assign bf_send_val[g] = sv_q;
    assign bf_cr[g] = cr_q;
    assign bf_cc[g] = cc_q;
    assign bf_dr[g] = dr_q;
    assign bf_dc[g] = dc_q;

    always @(posedge clk) begin
      if (reset) begin
        busy_q <= 1'b0;
        sv_q   <= 1'b0;
        cnt_q  <= 0;
      end else if (bf_recv_val[g] && !busy_q) begin
        l_ar <= bf_ar[g]; l_ac <= bf_ac[g];
        l_br <= bf_br[g]; l_bc <= bf_bc[g];
        l_wr <= bf_wr[g]; l_wc <= bf_wc[g];
        busy_q <= 1'b1;
        sv_q   <= 1'b0;
        cnt_q  <= 2;
      end else if (busy_q && cnt_q > 0) begin
        cnt_q <= cnt_q - 1;
        if (cnt_q == 1) begin
          sv_q <= 1'b1;
          cr_q <= l_ar + pr; cc_q <= l_ac + pc;
          dr_q <= l_ar - pr; dc_q <= l_ac - pc;
        end
      end else if (busy_q && sv_q && bf_send_rdy[g]) begin
        busy_q <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      for (int g = 0; g < NI; g++) begin
        if (bf_recv_val[g] && bf_recv_rdy[g]) n_iss[g] <= n_iss[g] + 1;
        if (bf_send_val[g] && bf_send_rdy[g]) n_cons[g] <= n_cons[g] + 1;
      end
    end
  end

  task automatic load_frame(input int g, input logic [31:0] xr [8], input logic [31:0] xc [8],
                            input bit stall, output int acc);
    int cyc;
    cyc = 0;
    acc = 0;
    while (acc < NS && cyc < 200) begin
      @(negedge clk);
      if (stall && (cyc % 2 == 1)) begin
        recv_val[g] = 1'b0;
      end else begin
        recv_val[g] = 1'b1;
        recv_r[g]   = xr[acc];
        recv_c[g]   = xc[acc];
        if (recv_rdy[g]) acc++;
      end
      cyc++;
    end
    @(posedge clk);
    #1 recv_val[g] = 1'b0;
  endtask

  task automatic collect_frame(input int g, input bit rnd, output logic [31:0] yr [8],
                               output logic [31:0] yc [8], output bit ok);
    int i, cyc;
    i = 0;
    cyc = 0;
    for (int j = 0; j < NS; j++) begin yr[j] = '0; yc[j] = '0; end
    while (i < NS && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      send_rdy[g] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (send_val[g] && send_rdy[g]) begin
        yr[i] = send_r[g];
        yc[i] = send_c[g];
        i++;
      end
    end
    @(posedge clk);
    #1 send_rdy[g] = 1'b0;
    ok = (i == NS);
  endtask

  task automatic ramp(output logic [31:0] xr [8], output logic [31:0] xc [8]);
    for (int i = 0; i < NS; i++) begin xr[i] = 32'(i) * ONE; xc[i] = '0; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int g = 0; g < NI; g++) begin
      total++; if (recv_rdy[g] !== 1'b1) $display("FAIL reset_recv_rdy[%0d] got %b want 1", g, recv_rdy[g]); else passed++;
      total++; if (send_val[g] !== 1'b0) $display("FAIL reset_send_val[%0d] got %b want 0", g, send_val[g]); else passed++;
      total++; if (bf_recv_val[g] !== 1'b0) $display("FAIL reset_bf_recv_val[%0d] got %b want 0", g, bf_recv_val[g]); else passed++;
      total++; if (bf_send_rdy[g] !== 1'b0) $display("FAIL reset_bf_send_rdy[%0d] got %b want 0", g, bf_send_rdy[g]); else passed++;
    end
  endtask

  task automatic test_identity(input bit rnd, input string nm);
    logic [31:0] xr [8], xc [8], yr [8], yc [8];
    int ev [8] = '{1, -1, 5, -1, 9, -1, 13, -1};
    int acc, i0, c0;
    bit ok;
    ramp(xr, xc);
    i0 = n_iss[0];
    c0 = n_cons[0];
    load_frame(0, xr, xc, 1'b0, acc);
    collect_frame(0, rnd, yr, yc, ok);
    total++; if (!ok) $display("FAIL %s_drain_timeout got %0d frames want 1", nm, 0); else passed++;
    for (int i = 0; i < NS; i++) begin
      total++; if (yr[i] !== 32'(ev[i] * 65536)) $display("FAIL %s_re[%0d] got %h want %h", nm, i, yr[i], 32'(ev[i] * 65536)); else passed++;
      total++; if (yc[i] !== 32'h0) $display("FAIL %s_im[%0d] got %h want 0", nm, i, yc[i]); else passed++;
    end
    total++; if (n_iss[0] - i0 !== 4) $display("FAIL %s_issues got %0d want 4", nm, n_iss[0] - i0); else passed++;
    total++; if (n_cons[0] - c0 !== 4) $display("FAIL %s_consumes got %0d want 4", nm, n_cons[0] - c0); else passed++;
  endtask

  task automatic test_stage2(input bit stall);
    logic [31:0] xr [8], xc [8], yr [8], yc [8];
    int ev [8] = '{4, 6, 8, 10, -4, -4, -4, -4};
    int acc;
    bit ok;
    ramp(xr, xc);
    load_frame(2, xr, xc, stall, acc);
    total++; if (acc !== NS) $display("FAIL s2_accepted got %0d want %0d", acc, NS); else passed++;
    recv_val[2] = 1'b1;
    recv_r[2]   = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (recv_rdy[2] !== 1'b0) $display("FAIL s2_recv_rdy_after_load[%0d] got %b want 0", c, recv_rdy[2]); else passed++;
    end
    recv_val[2] = 1'b0;
    collect_frame(2, 1'b0, yr, yc, ok);
    total++; if (!ok) $display("FAIL s2_drain_timeout got 0 frames want 1"); else passed++;
    for (int i = 0; i < NS; i++) begin
      total++; if (yr[i] !== 32'(ev[i] * 65536)) $display("FAIL s2_re[%0d] got %h want %h", i, yr[i], 32'(ev[i] * 65536)); else passed++;
      total++; if (yc[i] !== 32'h0) $display("FAIL s2_im[%0d] got %h want 0", i, yc[i]); else passed++;
    end
  endtask

  task automatic test_twiddle();
    logic [31:0] xr [8], xc [8], yr [8], yc [8];
    logic [31:0] er [8], ec [8];
    int acc;
    bit ok;
    for (int i = 0; i < NS; i++) begin xr[i] = '0; xc[i] = '0; er[i] = '0; ec[i] = '0; end
    xr[3] = ONE;
    ec[1] = 32'hFFFF_0000;
    ec[3] = ONE;
    load_frame(1, xr, xc, 1'b0, acc);
    collect_frame(1, 1'b0, yr, yc, ok);
    total++; if (!ok) $display("FAIL tw_drain_timeout got 0 frames want 1"); else passed++;
    for (int i = 0; i < NS; i++) begin
      total++; if (yr[i] !== er[i]) $display("FAIL tw_re[%0d] got %h want %h", i, yr[i], er[i]); else passed++;
      total++; if (yc[i] !== ec[i]) $display("FAIL tw_im[%0d] got %h want %h", i, yc[i], ec[i]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] xr [8], xc [8];
    int acc, i0, cyc;
    ramp(xr, xc);
    i0 = n_iss[0];
    load_frame(0, xr, xc, 1'b0, acc);
    cyc = 0;
    while (n_iss[0] - i0 < 3 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    total++; if (n_iss[0] - i0 < 3) $display("FAIL rmid_issue_timeout got %0d want 3", n_iss[0] - i0); else passed++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (recv_rdy[0] !== 1'b1) $display("FAIL rmid_recv_rdy got %b want 1", recv_rdy[0]); else passed++;
    total++; if (send_val[0] !== 1'b0) $display("FAIL rmid_send_val got %b want 0", send_val[0]); else passed++;
    test_identity(1'b0, "post_reset");
  endtask

  initial begin
    reset = 1'b1;
    for (int g = 0; g < NI; g++) begin
      recv_val[g] = 1'b0;
      send_rdy[g] = 1'b0;
      recv_r[g]   = '0;
      recv_c[g]   = '0;
      for (int j = 0; j < NS / 2; j++) begin
        tw_r[g][W*j +: W] = ONE;
        tw_c[g][W*j +: W] = '0;
      end
    end
    tw_r[1][W*2 +: W] = 32'h0;
    tw_c[1][W*2 +: W] = 32'hFFFF_0000;

    test_reset();
    test_identity(1'b0, "ident");
    test_stage2(1'b0);
    test_twiddle();
    test_identity(1'b1, "bp");
    test_reset_mid();
    test_stage2(1'b1);
    test_identity(1'b0, "back_to_back");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/butterfly_stage_sequencer.md
# butterfly_stage_sequencer

Sequences one radix-2 decimation-in-time FFT stage through a single shared butterfly unit. It buffers a frame of `N` complex samples, then issues `N/2` butterfly operations with the correct operand pairing and twiddle selection. It writes each result pair back in place and streams the frame out in index order. It sits between the sample stream and one butterfly instance; cascading `log2(N)` sequencers with `s = 0..log2(N)-1` forms a full FFT.

## Interface
- `n`, 32: sample word width, signed fixed point.
- `d`, 16: fractional bits; informational only, passed to the butterfly by the parent.
- `N`, 8: frame length; power of two, ≥ 4.
- `s`, 0: stage index, 0 ≤ s < log2(N).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `recv_val`  in  1  input sample valid.
- `recv_rdy`  out  1  sequencer accepts an input sample.
- `recv_r`, `recv_c`  in  n  input sample, real and imaginary parts.
- `send_val`  out  1  output sample valid.
- `send_rdy`  in  1  downstream accepts the output sample.
- `send_r`, `send_c`  out  n  output sample.
- `tw_r`, `tw_c`  in  n*N/2  twiddle table, entry j at bits [n*j +: n]; held static.
- `bf_recv_val`  out  1  operands valid to the butterfly.
- `bf_recv_rdy`  in  1  butterfly ready.
- `bf_ar`, `bf_ac`, `bf_br`, `bf_bc`, `bf_wr`, `bf_wc`  out  n  butterfly operands.
- `bf_send_val`  in  1  butterfly result valid.
- `bf_send_rdy`  out  1  sequencer consumes the result.
- `bf_cr`, `bf_cc`, `bf_dr`, `bf_dc`  in  n  butterfly results.

## Operation
- **States:** `LOAD`, `ISSUE`, `WAIT`, `DRAIN`.
- **LOAD**
  - `recv_rdy = 1`.
  - Each `recv_val & recv_rdy` writes `buf[ld_idx]` and increments `ld_idx`.
  - After index `N-1` is written: go to `ISSUE`, `ld_idx ← 0`.
- **Butterfly k (0 ≤ k < N/2) operand addressing**
  - `grp = k >> s`, `pos = k & (2^s − 1)`.
  - `top = grp·2^(s+1) + pos`, `bot = top + 2^s`.
  - Twiddle index `j = pos << (log2(N) − 1 − s)`.
- **ISSUE**
  - `bf_recv_val = 1`.
  - Operands: `a = buf[top]`, `b = buf[bot]`, `w = tw[j]`.
  - On `bf_recv_val & bf_recv_rdy`: go to `WAIT`.
  - Operands stay stable while `bf_recv_val = 1`.
- **WAIT**
  - `bf_recv_val = 0`.
  - On `bf_send_val = 1`:
    - Assert `bf_send_rdy` in that same cycle (combinational).
    - Write `buf[top] ← c` and `buf[bot] ← d`.
    - Increment `k`.
    - Go to `ISSUE`, or to `DRAIN` if `k` was `N/2 − 1`.
- **`bf_send_val` filtering:** `bf_send_val` outside `WAIT` is ignored. The butterfly holds `send_val` high after completion until its next accept, so stale assertions are expected.
- **DRAIN**
  - `send_val = 1`, `send_r/send_c = buf[out_idx]`.
  - Each `send_val & send_rdy` increments `out_idx`.
  - After index `N-1`: go to `LOAD`, counters cleared.
- **Arithmetic:** the sequencer does no arithmetic on samples; data passes bit-exact. Counters wrap only by explicit clear.

## Timing
- **Reset values**
  - State `LOAD`; all counters 0.
  - `recv_rdy = 1` (combinational from state).
  - `send_val`, `bf_recv_val`, `bf_send_rdy` = 0.
  - `send_*` and `bf_*` data outputs = `buf` contents; `buf` is not cleared.
- **Output decode:** all handshake outputs are decoded combinationally from the state register. `bf_send_rdy = (state == WAIT) & bf_send_val`.
- **Throughput:** one sample per cycle in `LOAD` and in `DRAIN`, absent backpressure.
- **Butterfly turnaround:** `WAIT → ISSUE` transition, then `ISSUE` stalls until `bf_recv_rdy` rises, one cycle after consume.
- **Frame latency:** N (load) + N/2·(L_bf + 2) + N (drain), minimum, where L_bf is the butterfly compute latency.
- **Backpressure:**
  - `recv_rdy` = 0 outside `LOAD`.
  - `send_rdy` = 0 holds `DRAIN` and `send_*` stable indefinitely.
- **Reset mid-operation:** takes priority over all transitions. The next cycle is in `LOAD`, and any partial frame is discarded. The parent resets the butterfly on the same reset.
- **Simultaneous events:** in `LOAD` the last-sample write and the state change occur in the same edge. `ISSUE` cannot accept while `bf_recv_rdy = 0`.

## Structure
- **Package `butterfly_seq_pkg`:**
  - State enum type `bfseq_state_t` (2 bits).
  - Localparam helper for clog2-derived widths.
- **Sub-module `stage_sample_buf`:** `N × 2n` register file, one async read pair (`top`/`bot`, or `out_idx`), two write ports.
  - Write port A: load / `top`.
  - Write port B: `bot`.
- The FSM, counters and address generation stay in the top module.

## Test plan
- **Identity stage** (N=8, s=0, all twiddles 1.0 = `0x00010000`, input `x[i] = i·1.0`): output real parts are 1, −1, 5, −1, 9, −1, 13, −1 (Q16.16); imaginary parts all 0.
- **Stage s=2** (N=8): same input and twiddles; output is 4, 6, 8, 10, −4, −4, −4, −4. Pairs are (0,4), (1,5), (2,6), (3,7).
- **Twiddle select** (N=8, s=1): `tw[2] = −j` (`wr = 0`, `wc = 0xFFFF0000`), input `x[3] = 1.0`, all other inputs 0. Expect `y[1] = −j` and `y[3] = +j`, with `tw[0]` used for `k` even.
- **Backpressure:** random `send_rdy` (50%) and the butterfly's stale `bf_send_val` high during `ISSUE`. Output matches the identity case, and no double consume or extra `bf_recv_val` pulse occurs.
- **Reset mid-compute:** reset after the third butterfly issue. The next cycle shows `recv_rdy = 1` and `send_val = 0`. A following full frame produces the correct output.
- **Input stall:** `recv_val` toggled 1/0 during `LOAD`. Exactly `N` samples are accepted, and `recv_rdy` drops on the cycle after the 8th accept.
